// File: rtl/lane_word_sched_pkg.sv
// Shared types and constants for the four-lane word scheduler that feeds the 8-to-32 packer.
package lane_sched_pkg;

  localparam int NUM_LANES          = 4;
  localparam int LANE_W             = 2;
  localparam int BYTES_PER_WORD_DEF = 4;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_PAD
  } state_t;

  // Byte of lane idx out of the flattened lane data bus.
  function automatic logic [7:0] lane_byte(input logic [8*NUM_LANES-1:0] data, input lane_t idx);
    return data[8*idx +: 8];
  endfunction

endpackage

// File: rtl/lane_word_sched_if.sv
// Byte-lane request side and packer-facing side of the scheduler, bundled as one interface.
interface lane_word_sched_if;
  import lane_sched_pkg::*;

  logic [8*NUM_LANES-1:0] in_data;
  logic [NUM_LANES-1:0]   in_valid;
  logic [NUM_LANES-1:0]   in_ready;
  logic [7:0]             mux_data;
  logic                   mux_valid;
  logic [NUM_LANES-1:0]   grant;
  lane_t                  word_lane;
  logic                   word_start;
  logic                   err_abort;

  // master: the scheduler; slave: the lanes and the packer around it.
  modport master (
    input  in_data, in_valid,
    output in_ready, mux_data, mux_valid, grant, word_lane, word_start, err_abort
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mux_data, mux_valid, grant, word_lane, word_start, err_abort
  );

endinterface

// File: rtl/lane_word_sched_rr_arbiter_4.sv
// Combinational round-robin pick: first requester after 'last', wrapping, with 'last' itself lowest.
module rr_arbiter_4
  import lane_sched_pkg::*;
(
  input  logic [NUM_LANES-1:0] req,
  input  lane_t                last,
  output logic [NUM_LANES-1:0] gnt,
  output lane_t                gnt_idx
);

  lane_t cand;

  // NOTE: every always_comb output gets a default before any branch, otherwise a latch is inferred.
  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    cand    = last;
    // Walk from lowest to highest priority so the highest-priority requester is written last.
    for (int k = NUM_LANES; k >= 1; k--) begin
      cand = last + lane_t'(k);
      if (req[cand]) begin
        gnt     = {{(NUM_LANES-1){1'b0}}, 1'b1} << cand;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/lane_word_sched.sv
// Shares the byte packer among four lanes one word at a time; pads out a word when its lane stalls.
module lane_word_sched
  import lane_sched_pkg::*;
#(
  parameter int         BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int         STALL_MAX      = 8,
  parameter logic [7:0] PAD_BYTE       = 8'h00
) (
  input  logic             clk_4f,
  input  logic             reset,
  lane_word_sched_if.master bus
);

  localparam logic [7:0] CNT_LAST   = 8'(BYTES_PER_WORD - 1);
  localparam logic [7:0] STALL_LAST = 8'(STALL_MAX - 1);

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] grant_q, grant_d;
  lane_t                idx_q, idx_d;
  lane_t                last_q, last_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           stall_q, stall_d;
  logic [7:0]           mux_data_q, mux_data_d;
  logic                 mux_valid_q, mux_valid_d;
  lane_t                word_lane_q, word_lane_d;
  logic                 word_start_q, word_start_d;
  logic                 err_abort_q, err_abort_d;

  logic [NUM_LANES-1:0] in_ready;
  logic                 pop;
  logic [NUM_LANES-1:0] arb_gnt;
  lane_t                arb_idx;
  lane_t                arb_last;

  assign in_ready = (state_q == ST_BURST) ? (grant_q & bus.in_valid) : '0;
  assign pop      = |in_ready;
  // At the end of a burst the lane just served becomes the pointer for the same-cycle re-arbitration.
  assign arb_last = (state_q == ST_BURST) ? idx_q : last_q;

  rr_arbiter_4 u_arb (
    .req     (bus.in_valid),
    .last    (arb_last),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    idx_d        = idx_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    stall_d      = stall_q;
    mux_data_d   = mux_data_q;
    mux_valid_d  = 1'b0;
    word_lane_d  = word_lane_q;
    word_start_d = 1'b0;
    err_abort_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.in_valid) begin
          grant_d = arb_gnt;
          idx_d   = arb_idx;
          state_d = ST_BURST;
        end
      end

      ST_BURST: begin
        if (pop) begin
          mux_data_d  = lane_byte(bus.in_data, idx_q);
          mux_valid_d = 1'b1;
          stall_d     = '0;
          if (cnt_q == '0) begin
            word_start_d = 1'b1;
            word_lane_d  = idx_q;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            last_d = idx_q;
            if (|bus.in_valid) begin
              grant_d = arb_gnt;
              idx_d   = arb_idx;
            end else begin
              grant_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          stall_d = stall_q + 8'd1;
          if (stall_q == STALL_LAST) state_d = ST_PAD;
        end
      end

      ST_PAD: begin
        mux_data_d  = PAD_BYTE;
        mux_valid_d = 1'b1;
        // Stall count is non-zero only on the first pad cycle.
        err_abort_d = (stall_q != '0);
        stall_d     = '0;
        if (cnt_q == '0) begin
          word_start_d = 1'b1;
          word_lane_d  = idx_q;
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          last_d  = idx_q;
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      idx_q        <= '0;
      last_q       <= lane_t'(NUM_LANES - 1);
      cnt_q        <= '0;
      stall_q      <= '0;
      mux_data_q   <= '0;
      mux_valid_q  <= 1'b0;
      word_lane_q  <= '0;
      word_start_q <= 1'b0;
      err_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      stall_q      <= stall_d;
      mux_data_q   <= mux_data_d;
      mux_valid_q  <= mux_valid_d;
      word_lane_q  <= word_lane_d;
      word_start_q <= word_start_d;
      err_abort_q  <= err_abort_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.mux_data   = mux_data_q;
  assign bus.mux_valid  = mux_valid_q;
  assign bus.grant      = grant_q;
  assign bus.word_lane  = word_lane_q;
  assign bus.word_start = word_start_q;
  assign bus.err_abort  = err_abort_q;

endmodule

// File: tb/tb_lane_word_sched.sv
// Scoreboard bench for lane_word_sched: directed lane streams in, expected byte/lane/flag sequence checked out.
module tb_lane_word_sched;
  import lane_sched_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] lane;
    logic       start;
    logic       abort;
  } exp_t;

  logic clk_4f = 1'b0;
  logic reset;

  lane_word_sched_if bus ();

  lane_word_sched dut (
    .clk_4f (clk_4f),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_4f = ~clk_4f;

  exp_t       exp_q[$];
  int         obs_cyc[$];
  logic [7:0] lane_q[4][$];
  int         pops_done[4];
  int         gap_at[4];
  int         gap_left[4];
  bit         hold_now[4];
  int         cyc;
  int         n_pass;
  int         n_checks;
  bit         mon_en;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, want);
  endtask

  function automatic void update_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid[i]       = (lane_q[i].size() > 0) && !hold_now[i];
      bus.in_data[8*i +: 8] = (lane_q[i].size() > 0) ? lane_q[i][0] : 8'h00;
    end
  endfunction

  // Lane model: a byte leaves its queue when valid & ready was seen with reset released.
  task automatic driver();
    logic [3:0] pend;
    forever begin
      @(negedge clk_4f);
      #1 update_inputs();
      #1 pend = bus.in_valid & bus.in_ready & {4{reset}};
      @(posedge clk_4f);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          void'(lane_q[i].pop_front());
          pops_done[i]++;
        end
        hold_now[i] = (pops_done[i] >= gap_at[i]) && (gap_left[i] > 0);
        if (hold_now[i]) gap_left[i]--;
      end
      update_inputs();
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_4f);
      cyc++;
      if (mon_en) begin
        check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        check("pulse_without_valid", 32'((bus.word_start | bus.err_abort) & ~bus.mux_valid), 32'd0);
        if (bus.mux_valid) begin
          obs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL extra_byte: got data %0h lane %0d, expected no byte", bus.mux_data, bus.word_lane);
          end else begin
            e = exp_q.pop_front();
            check("byte{data,lane,start,abort}",
                  32'({bus.mux_data, bus.word_lane, bus.word_start, bus.err_abort}), 32'(e));
          end
        end
      end
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [1:0] l, input logic s, input logic a);
    exp_t e;
    e.data  = d;
    e.lane  = l;
    e.start = s;
    e.abort = a;
    exp_q.push_back(e);
  endtask

  task automatic exp_word(input logic [1:0] l, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    push_exp(b0, l, 1'b1, 1'b0);
    push_exp(b1, l, 1'b0, 1'b0);
    push_exp(b2, l, 1'b0, 1'b0);
    push_exp(b3, l, 1'b0, 1'b0);
  endtask

  // A lane still valid while its final byte pops is regranted, stalls STALL_MAX cycles and pads a full word.
  task automatic exp_pad_word(input logic [1:0] l);
    push_exp(8'h00, l, 1'b1, 1'b1);
    push_exp(8'h00, l, 1'b0, 1'b0);
    push_exp(8'h00, l, 1'b0, 1'b0);
    push_exp(8'h00, l, 1'b0, 1'b0);
  endtask

  task automatic load(input int l, input logic [7:0] b);
    lane_q[l].push_back(b);
  endtask

  task automatic set_gap(input int l, input int after_pops, input int len);
    gap_at[l]   = pops_done[l] + after_pops;
    gap_left[l] = len;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.grant != '0) && n < 400) begin
      @(negedge clk_4f);
      n++;
    end
    check({name, "_drained"}, 32'(n < 400), 32'd1);
    repeat (4) @(negedge clk_4f);
  endtask

  task automatic wait_byte(input logic [7:0] b, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_4f);
      n++;
    end while (!(bus.mux_valid && bus.mux_data == b) && n < 40);
    check({name, "_seen"}, 32'(n < 40), 32'd1);
  endtask

  initial begin
    int ord[3];
    int n;
    ord = '{0, 1, 3};
    reset         = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    mon_en        = 1'b0;
    n_pass        = 0;
    n_checks      = 0;
    cyc           = 0;
    for (int i = 0; i < 4; i++) begin
      pops_done[i] = 0;
      gap_at[i]    = 0;
      gap_left[i]  = 0;
      hold_now[i]  = 1'b0;
    end
    fork
      driver();
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk_4f);
    check("rst_mux_data",   32'(bus.mux_data),   32'd0);
    check("rst_mux_valid",  32'(bus.mux_valid),  32'd0);
    check("rst_grant",      32'(bus.grant),      32'd0);
    check("rst_word_lane",  32'(bus.word_lane),  32'd0);
    check("rst_word_start", 32'(bus.word_start), 32'd0);
    check("rst_err_abort",  32'(bus.err_abort),  32'd0);
    check("rst_in_ready",   32'(bus.in_ready),   32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Single lane 2, continuous
    obs_cyc.delete();
    load(2, 8'h11); load(2, 8'h22); load(2, 8'h33); load(2, 8'h44);
    exp_word(2'd2, 8'h11, 8'h22, 8'h33, 8'h44);
    exp_pad_word(2'd2);
    n = 0;
    do begin
      @(negedge clk_4f);
      n++;
    end while (bus.grant == '0 && n < 20);
    check("t1_first_grant", 32'(bus.grant), 32'b0100);
    drain("t1");
    check("t1_word_span", 32'(obs_cyc[3] - obs_cyc[0]), 32'd3);

    // Contention on lanes 0,1,3 after a fresh reset (pointer back to 3)
    @(negedge clk_4f) reset = 1'b0;
    @(negedge clk_4f) reset = 1'b1;
    obs_cyc.delete();
    for (int w = 0; w < 3; w++)
      for (int j = 0; j < 4; j++)
        for (int k = 0; k < 3; k++) load(ord[k], 8'(ord[k] * 64 + w * 4 + j));
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 3; k++)
        exp_word(2'(ord[k]), 8'(ord[k] * 64 + w * 4), 8'(ord[k] * 64 + w * 4 + 1),
                 8'(ord[k] * 64 + w * 4 + 2), 8'(ord[k] * 64 + w * 4 + 3));
    exp_pad_word(2'd3);
    drain("t2");
    check("t2_no_bubble_span", 32'(obs_cyc[35] - obs_cyc[0]), 32'd35);

    // Gap tolerance: lane 1 invalid for 3 cycles after its first byte
    obs_cyc.delete();
    set_gap(1, 1, 3);
    load(1, 8'h51); load(1, 8'h52); load(1, 8'h53); load(1, 8'h54);
    exp_word(2'd1, 8'h51, 8'h52, 8'h53, 8'h54);
    exp_pad_word(2'd1);
    drain("t3");
    check("t3_gap_cycles", 32'(obs_cyc[1] - obs_cyc[0]), 32'd4);
    check("t3_after_gap",  32'(obs_cyc[3] - obs_cyc[2]), 32'd1);

    // Abort: lane 0 stalls after two bytes; lane 1 must be served before lane 0 again
    set_gap(0, 2, 12);
    load(0, 8'h61); load(0, 8'h62); load(0, 8'h63); load(0, 8'h64); load(0, 8'h65); load(0, 8'h66);
    load(1, 8'h71); load(1, 8'h72); load(1, 8'h73); load(1, 8'h74);
    push_exp(8'h61, 2'd0, 1'b1, 1'b0);
    push_exp(8'h62, 2'd0, 1'b0, 1'b0);
    push_exp(8'h00, 2'd0, 1'b0, 1'b1);
    push_exp(8'h00, 2'd0, 1'b0, 1'b0);
    exp_word(2'd1, 8'h71, 8'h72, 8'h73, 8'h74);
    exp_word(2'd0, 8'h63, 8'h64, 8'h65, 8'h66);
    exp_pad_word(2'd0);
    drain("t4");

    // Reset after lane 3's first byte: partial word dropped, lane 0 wins after release
    load(3, 8'h81); load(3, 8'h82); load(3, 8'h83); load(3, 8'h84); load(3, 8'h85);
    load(0, 8'h91); load(0, 8'h92); load(0, 8'h93); load(0, 8'h94);
    push_exp(8'h81, 2'd3, 1'b1, 1'b0);
    exp_word(2'd0, 8'h91, 8'h92, 8'h93, 8'h94);
    exp_word(2'd3, 8'h82, 8'h83, 8'h84, 8'h85);
    exp_pad_word(2'd3);
    wait_byte(8'h81, "t5_byte0");
    reset = 1'b0;
    @(negedge clk_4f);
    check("t5_rst_mux_data",   32'(bus.mux_data),   32'd0);
    check("t5_rst_mux_valid",  32'(bus.mux_valid),  32'd0);
    check("t5_rst_grant",      32'(bus.grant),      32'd0);
    check("t5_rst_word_lane",  32'(bus.word_lane),  32'd0);
    check("t5_rst_word_start", 32'(bus.word_start), 32'd0);
    check("t5_rst_err_abort",  32'(bus.err_abort),  32'd0);
    check("t5_rst_in_ready",   32'(bus.in_ready),   32'd0);
    reset = 1'b1;
    drain("t5");

    // Lane 3 raises valid while lane 2 pops its last byte: no bubble between the words
    obs_cyc.delete();
    load(2, 8'hA1); load(2, 8'hA2); load(2, 8'hA3); load(2, 8'hA4);
    exp_word(2'd2, 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    exp_word(2'd3, 8'hB1, 8'hB2, 8'hB3, 8'hB4);
    exp_pad_word(2'd3);
    wait_byte(8'hA3, "t6_byte2");
    load(3, 8'hB1); load(3, 8'hB2); load(3, 8'hB3); load(3, 8'hB4);
    drain("t6");
    check("t6_no_bubble_span", 32'(obs_cyc[7] - obs_cyc[0]), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected the bench to finish");
    $fatal(1, "watchdog");
  end

endmodule
